multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core variant. Per instruction, it sequences the shared ALU, register file, instruction register and unified memory through fetch, decode, execute, memory and writeback steps. It generates the mux selects, write enables and the 3-bit ALUControl code in the team's standard ALU encoding. It replaces the single-cycle main decoder plus ALU decoder pair when the datapath is built around one ALU and one memory port.

Parameters:
STATE_W, 4, width of state register and state_o debug port
WAIT_MEM, 1, 1 = FETCH/MEMREAD hold until mem_ready; 0 = mem_ready ignored (treated as 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
op  input  7  instruction opcode (IR[6:0])
funct3  input  3  IR[14:12]
funct7b5  input  1  IR[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory read data valid this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register (and OldPC) enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 register
ALUSrcB  output  2  00 rs2 register, 01 ImmExt, 10 constant 4
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
state_o  output  STATE_W  current state, debug only

Behaviour:
- Supported opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10. Encodings 11–15 are unused and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE when mem_ready, else hold.
  - DECODE -> MEMADR for lw/sw, EXECR for R, EXECI for I-ALU, JAL for jal, BEQ for beq. Any other opcode -> FETCH, with illegal_op = 1 that cycle.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB when mem_ready, else hold.
  - MEMWB, MEMWRITE, BEQ -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB.
  - ALUWB -> FETCH.
- Outputs are a Moore decode of state, except:
  - PCWrite = PCUpdate | (Branch & zero).
  - In FETCH, IRWrite and PCUpdate are gated by mem_ready.
  - Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: AdrSrc 0, IRWrite, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add (branch/jump target precompute).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp add.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp add, ResultSrc 00, PCUpdate.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch.
- ALUControl:
  - ALUOp add -> 000; ALUOp sub -> 001.
  - ALUOp funct: funct3 000 -> 001 if (op[5] & funct7b5), else 000.
  - ALUOp funct: funct3 010 -> 101, 110 -> 011, 111 -> 010, other -> 000.
- ImmSrc is combinational from op in every state: sw 01, beq 10, jal 11, all others 00.
- Latency in cycles, with mem_ready always 1: lw 5, sw 4, R/I 4, jal 4, beq 3. Each mem_ready-low cycle in FETCH or MEMREAD adds one cycle.
- Reset:
  - rst sampled high -> state = FETCH at that edge, from any state including mid-instruction.
  - While rst is high, PCWrite, IRWrite, RegWrite, MemWrite and illegal_op are forced 0. Selects show FETCH values.
  - First fetch occurs in the cycle after rst deasserts.
- beq with zero = 0: PCWrite stays 0 in BEQ and the PC keeps the PC+4 value written in FETCH.

Test Plan:
- rst high 2 cycles mid-EXECR -> state_o = 0, all write enables 0 during reset. Next cycle FETCH with IRWrite = 1, PCWrite = 1 (mem_ready = 1).
- lw (op 0000011), mem_ready = 1 -> states 0,1,2,3,4. MEMWB: RegWrite = 1, ResultSrc = 01. ImmSrc = 00 throughout.
- sub R-type (op 0110011, funct3 000, funct7b5 1) -> EXECR ALUControl = 001. Same with funct7b5 0 -> 000. addi with funct7b5 1 (op 0010011) -> 000.
- beq with zero = 1 -> BEQ: PCWrite = 1, ALUControl = 001. Repeat with zero = 0 -> PCWrite = 0, returns to FETCH after 3 cycles.
- mem_ready low 3 cycles in FETCH, then in MEMREAD -> state holds, IRWrite/PCWrite = 0 while low. lw completes in 11 cycles.
- op 1111111 -> DECODE pulses illegal_op = 1 for one cycle, next state FETCH, no RegWrite/MemWrite asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
// Per instruction it steps the shared ALU, register file, instruction register
// and unified memory port through fetch / decode / execute / memory / writeback,
// and drives the datapath selects, write enables and the 3-bit ALU code.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the IR
//   zero                ALU zero flag (branch resolve in BEQ)
//   mem_ready           memory read data valid this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite     datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl  datapath mux/ALU codes
//   illegal_op          one-cycle pulse in DECODE for an unsupported opcode
//   state_o             current state (debug)
//
// The state is registered; the outputs are a decode of the state plus the
// same-cycle qualifiers (mem_ready in FETCH, zero in BEQ, rst), because those
// qualifiers must act in the cycle they are presented.
module multicycle_controller #(
  parameter int unsigned STATE_W  = 4,
  parameter bit          WAIT_MEM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  state_t state;
  state_t next_state;
  state_t dec_state;
  aluop_t alu_op;
  logic   mem_ok;
  logic   pc_update;
  logic   branch;
  logic   ir_write;
  logic   reg_write;
  logic   mem_write;
  logic   supported;

  // With WAIT_MEM = 0 the memory is assumed always ready.
  assign mem_ok = WAIT_MEM ? mem_ready : 1'b1;

  assign supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                     (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

  // State register; reset wins from any state.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = S_FETCH;
    unique case (state)
      S_FETCH:   next_state = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) next_state = S_MEMADR;
        else if (op == OP_R)                next_state = S_EXECR;
        else if (op == OP_I)                next_state = S_EXECI;
        else if (op == OP_JAL)              next_state = S_JAL;
        else if (op == OP_BEQ)              next_state = S_BEQ;
        else                                next_state = S_FETCH;
      end
      S_MEMADR:   next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = mem_ok ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_JAL:      next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values whatever the current state is.
  assign dec_state = rst ? S_FETCH : state;

  // Per-state output decode.
  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    unique case (dec_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ok;
        pc_update = mem_ok;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are forced off while reset is asserted.
  assign PCWrite    = ~rst & (pc_update | (branch & zero));
  assign IRWrite    = ~rst & ir_write;
  assign RegWrite   = ~rst & reg_write;
  assign MemWrite   = ~rst & mem_write;
  assign illegal_op = ~rst & (state == S_DECODE) & ~supported;

  // ALU decoder; only R-type (op[5] set) turns funct3 000 into sub.
  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = 2'b00;
    if (op == OP_SW)       ImmSrc = 2'b01;
    else if (op == OP_BEQ) ImmSrc = 2'b10;
    else if (op == OP_JAL) ImmSrc = 2'b11;
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-cycle vector table for the
// main instruction flows, plus hand sequences for reset mid-instruction and
// mem_ready stalls.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  out_t       act;

  int total  = 0;
  int passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4), .WAIT_MEM(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  assign act = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op};

  function automatic out_t mk(int st, int pcw, int adr, int mw, int irw, int rw,
                              int rs, int sa, int sb, int imm, int alu, int ill);
    out_t o;
    o.st  = 4'(st);
    o.pcw = 1'(pcw);
    o.adr = 1'(adr);
    o.mw  = 1'(mw);
    o.irw = 1'(irw);
    o.rw  = 1'(rw);
    o.rs  = 2'(rs);
    o.sa  = 2'(sa);
    o.sb  = 2'(sb);
    o.imm = 2'(imm);
    o.alu = 3'(alu);
    o.ill = 1'(ill);
    return o;
  endfunction

  task automatic add(string n, logic r, logic [6:0] o, logic [2:0] f3, logic f7,
                     logic z, logic mr, out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string n, out_t got, out_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (st,pcw,adr,mw,irw,rw,rs,sa,sb,imm,alu,ill)",
                  n, got, exp);
  endtask

  task automatic drive(logic r, logic [6:0] o, logic [2:0] f3, logic f7, logic z, logic mr);
    rst = r; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = mr;
  endtask

  // Safety net against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic mr_seq [0:10];
  out_t st_seq [0:11];

  initial begin
    drive(1'b1, LW, 3'b000, 1'b0, 1'b0, 1'b1);

    // Cycle-by-cycle table: inputs for the cycle and the outputs expected in it.
    add("reset_hold",  1, LW, 0, 0, 0, 1, mk(0,0,0,0,0,0,2,0,2,0,0,0));
    add("lw_fetch",    0, LW, 0, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("lw_decode",   0, LW, 0, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("lw_memadr",   0, LW, 0, 0, 0, 1, mk(2,0,0,0,0,0,0,2,1,0,0,0));
    add("lw_memread",  0, LW, 0, 0, 0, 1, mk(3,0,1,0,0,0,0,0,0,0,0,0));
    add("lw_memwb",    0, LW, 0, 0, 0, 1, mk(4,0,0,0,0,1,1,0,0,0,0,0));
    add("sw_fetch",    0, SW, 2, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,1,0,0));
    add("sw_decode",   0, SW, 2, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,1,0,0));
    add("sw_memadr",   0, SW, 2, 0, 0, 1, mk(2,0,0,0,0,0,0,2,1,1,0,0));
    add("sw_memwrite", 0, SW, 2, 0, 0, 1, mk(5,0,1,1,0,0,0,0,0,1,0,0));
    add("sub_fetch",   0, RT, 0, 1, 1, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("sub_decode",  0, RT, 0, 1, 1, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("sub_execr",   0, RT, 0, 1, 1, 1, mk(6,0,0,0,0,0,0,2,0,0,1,0));
    add("sub_aluwb",   0, RT, 0, 1, 1, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("add_fetch",   0, RT, 0, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("add_decode",  0, RT, 0, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("add_execr",   0, RT, 0, 0, 0, 1, mk(6,0,0,0,0,0,0,2,0,0,0,0));
    add("add_aluwb",   0, RT, 0, 0, 0, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("addi_fetch",  0, IT, 0, 1, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("addi_decode", 0, IT, 0, 1, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("addi_execi",  0, IT, 0, 1, 0, 1, mk(8,0,0,0,0,0,0,2,1,0,0,0));
    add("addi_aluwb",  0, IT, 0, 1, 0, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("and_fetch",   0, RT, 7, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("and_decode",  0, RT, 7, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("and_execr",   0, RT, 7, 0, 0, 1, mk(6,0,0,0,0,0,0,2,0,0,2,0));
    add("and_aluwb",   0, RT, 7, 0, 0, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("slti_fetch",  0, IT, 2, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("slti_decode", 0, IT, 2, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("slti_execi",  0, IT, 2, 0, 0, 1, mk(8,0,0,0,0,0,0,2,1,0,5,0));
    add("slti_aluwb",  0, IT, 2, 0, 0, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("or_fetch",    0, RT, 6, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("or_decode",   0, RT, 6, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    add("or_execr",    0, RT, 6, 0, 0, 1, mk(6,0,0,0,0,0,0,2,0,0,3,0));
    add("or_aluwb",    0, RT, 6, 0, 0, 1, mk(7,0,0,0,0,1,0,0,0,0,0,0));
    add("jal_fetch",   0, JL, 0, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,3,0,0));
    add("jal_decode",  0, JL, 0, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,3,0,0));
    add("jal_jal",     0, JL, 0, 0, 0, 1, mk(9,1,0,0,0,0,0,1,2,3,0,0));
    add("jal_aluwb",   0, JL, 0, 0, 0, 1, mk(7,0,0,0,0,1,0,0,0,3,0,0));
    add("beqt_fetch",  0, BQ, 0, 0, 1, 1, mk(0,1,0,0,1,0,2,0,2,2,0,0));
    add("beqt_decode", 0, BQ, 0, 0, 1, 1, mk(1,0,0,0,0,0,0,1,1,2,0,0));
    add("beqt_beq",    0, BQ, 0, 0, 1, 1, mk(10,1,0,0,0,0,0,2,0,2,1,0));
    add("beqn_fetch",  0, BQ, 0, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,2,0,0));
    add("beqn_decode", 0, BQ, 0, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,2,0,0));
    add("beqn_beq",    0, BQ, 0, 0, 0, 1, mk(10,0,0,0,0,0,0,2,0,2,1,0));
    add("bad_fetch",   0, BAD,0, 0, 0, 1, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    add("bad_decode",  0, BAD,0, 0, 0, 1, mk(1,0,0,0,0,0,0,1,1,0,0,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z, vecs[i].mr);
      #1;
      check(vecs[i].name, act, vecs[i].exp);
    end

    // Reset held for two cycles in the middle of an R-type instruction.
    @(negedge clk); drive(0, RT, 0, 1, 0, 1); #1;
    check("rr_fetch_after_illegal", act, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    @(negedge clk); drive(0, RT, 0, 1, 0, 1); #1;
    check("rr_decode", act, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    @(negedge clk); drive(1, RT, 0, 1, 0, 1); #1;
    check("rr_rst_in_execr", act, mk(6,0,0,0,0,0,2,0,2,0,0,0));
    @(negedge clk); drive(1, RT, 0, 1, 0, 1); #1;
    check("rr_rst_second", act, mk(0,0,0,0,0,0,2,0,2,0,0,0));
    @(negedge clk); drive(0, LW, 0, 0, 0, 1); #1;
    check("rr_first_fetch", act, mk(0,1,0,0,1,0,2,0,2,0,0,0));
    @(negedge clk); drive(0, LW, 0, 0, 0, 1); #1;
    check("rr_decode_lw", act, mk(1,0,0,0,0,0,0,1,1,0,0,0));
    @(negedge clk); drive(0, LW, 0, 0, 0, 1); #1;
    check("rr_memadr_lw", act, mk(2,0,0,0,0,0,0,2,1,0,0,0));
    @(negedge clk); drive(0, LW, 0, 0, 0, 1); #1;
    check("rr_memread_lw", act, mk(3,0,1,0,0,0,0,0,0,0,0,0));
    @(negedge clk); drive(0, LW, 0, 0, 0, 1); #1;
    check("rr_memwb_lw", act, mk(4,0,0,0,0,1,1,0,0,0,0,0));

    // lw with three stall cycles in FETCH and three in MEMREAD: 11 cycles.
    mr_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 3; c++) st_seq[c] = mk(0,0,0,0,0,0,2,0,2,0,0,0);
    st_seq[3] = mk(0,1,0,0,1,0,2,0,2,0,0,0);
    st_seq[4] = mk(1,0,0,0,0,0,0,1,1,0,0,0);
    st_seq[5] = mk(2,0,0,0,0,0,0,2,1,0,0,0);
    for (int c = 6; c < 10; c++) st_seq[c] = mk(3,0,1,0,0,0,0,0,0,0,0,0);
    st_seq[10] = mk(4,0,0,0,0,1,1,0,0,0,0,0);
    st_seq[11] = mk(0,1,0,0,1,0,2,0,2,0,0,0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive(0, LW, 0, 0, 0, (c < 11) ? mr_seq[c] : 1'b1);
      #1;
      check($sformatf("stall_lw_c%0d", c), act, st_seq[c]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
